// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle between the register-read stage, the ALU
// and write-back. The producer side is the master; the ALU is the slave.
interface alu_seq_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [4:0]       fsec;
  logic             carry;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] fout;
  logic             flag_c;
  logic             flag_z;
  logic             flag_n;
  logic             flag_v;
  logic             err;

  modport master (
    output in_valid, a, b, fsec, carry, out_ready,
    input  in_ready, out_valid, fout, flag_c, flag_z, flag_n, flag_v, err
  );

  modport slave (
    input  in_valid, a, b, fsec, carry, out_ready,
    output in_ready, out_valid, fout, flag_c, flag_z, flag_n, flag_v, err
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked WIDTH-bit ALU, one transaction in flight, registered result and C/Z/N/V flags.
// Define ALU_SHIFT_EN to build the iterative shifter (SLL/SRL/SRA/ROL, one bit position per cycle).
module alu_seq #(
  parameter int WIDTH = 64
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_ADC   = 5'd1;
  localparam logic [4:0] OP_SUB   = 5'd2;
  localparam logic [4:0] OP_RSB   = 5'd3;
  localparam logic [4:0] OP_INC   = 5'd4;
  localparam logic [4:0] OP_DEC   = 5'd5;
  localparam logic [4:0] OP_AND   = 5'd8;
  localparam logic [4:0] OP_OR    = 5'd9;
  localparam logic [4:0] OP_XOR   = 5'd10;
  localparam logic [4:0] OP_NOT   = 5'd11;
  localparam logic [4:0] OP_PASSB = 5'd12;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t           state_r, state_s;
  logic             in_ready_r, out_valid_r;
  logic [WIDTH-1:0] fout_r, fout_s;
  logic             c_r, c_s, z_r, z_s, n_r, n_s, v_r, v_s, err_r, err_s;

  logic [WIDTH-1:0] x_s, y_s, res_s;
  logic             cin_s, ovf_s, rc_s, rv_s, rerr_s, go_shift_s;
  logic [WIDTH:0]   sum_s;

`ifdef ALU_SHIFT_EN
  localparam logic [4:0] OP_SLL = 5'd16;
  localparam logic [4:0] OP_SRL = 5'd17;
  localparam logic [4:0] OP_SRA = 5'd18;
  localparam logic [4:0] OP_ROL = 5'd19;
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] work_r, work_s, shifted_s;
  logic [SHW-1:0]   cnt_r, cnt_s;
  logic [1:0]       shop_r, shop_s;
  logic             sc_s;

  // Only the low SHW bits of b form the shift amount; n = 0 completes like a non-shift op.
  assign go_shift_s = (bus.fsec[4:2] == 3'b100) && (bus.b[SHW-1:0] != {SHW{1'b0}});

  // One-position step of the working register; sc_s is the bit leaving (or wrapping) this cycle.
  always_comb begin
    shifted_s = work_r;
    sc_s      = 1'b0;
    case (shop_r)
      2'd0: begin shifted_s = {work_r[WIDTH-2:0], 1'b0};         sc_s = work_r[WIDTH-1]; end
      2'd1: begin shifted_s = {1'b0, work_r[WIDTH-1:1]};         sc_s = work_r[0];       end
      2'd2: begin shifted_s = {work_r[WIDTH-1], work_r[WIDTH-1:1]}; sc_s = work_r[0];    end
      2'd3: begin shifted_s = {work_r[WIDTH-2:0], work_r[WIDTH-1]}; sc_s = work_r[WIDTH-1]; end
      default: begin shifted_s = work_r; sc_s = 1'b0; end
    endcase
  end

  // Shifter working state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_r <= {WIDTH{1'b0}};
      cnt_r  <= {SHW{1'b0}};
      shop_r <= 2'd0;
    end else begin
      work_r <= work_s;
      cnt_r  <= cnt_s;
      shop_r <= shop_s;
    end
  end
`else
  assign go_shift_s = 1'b0;
`endif

  // All arithmetic ops share one adder: x + y + cin, with subtraction as x + ~y + 1.
  always_comb begin
    x_s   = bus.a;
    y_s   = bus.b;
    cin_s = 1'b0;
    case (bus.fsec)
      OP_ADC:  cin_s = bus.carry;
      OP_SUB:  begin y_s = ~bus.b; cin_s = 1'b1; end
      OP_RSB:  begin x_s = bus.b; y_s = ~bus.a; cin_s = 1'b1; end
      OP_INC:  y_s = ONE;
      OP_DEC:  begin y_s = ~ONE; cin_s = 1'b1; end
      default: begin x_s = bus.a; y_s = bus.b; cin_s = 1'b0; end
    endcase
  end

  assign sum_s = {1'b0, x_s} + {1'b0, y_s} + {{WIDTH{1'b0}}, cin_s};
  assign ovf_s = (x_s[WIDTH-1] == y_s[WIDTH-1]) && (sum_s[WIDTH-1] != x_s[WIDTH-1]);

  // Single-cycle result; an illegal opcode yields zero data and raises err.
  always_comb begin
    res_s  = {WIDTH{1'b0}};
    rc_s   = 1'b0;
    rv_s   = 1'b0;
    rerr_s = 1'b0;
    case (bus.fsec)
      OP_ADD, OP_ADC, OP_SUB, OP_RSB, OP_INC, OP_DEC: begin
        res_s = sum_s[WIDTH-1:0];
        rc_s  = sum_s[WIDTH];
        rv_s  = ovf_s;
      end
      OP_AND:   res_s = bus.a & bus.b;
      OP_OR:    res_s = bus.a | bus.b;
      OP_XOR:   res_s = bus.a ^ bus.b;
      OP_NOT:   res_s = ~bus.a;
      OP_PASSB: res_s = bus.b;
`ifdef ALU_SHIFT_EN
      OP_SLL, OP_SRL, OP_SRA, OP_ROL: res_s = bus.a;
`endif
      default:  rerr_s = 1'b1;
    endcase
  end

  // Control FSM: next state plus next values of the held result registers.
  always_comb begin
    state_s = state_r;
    fout_s  = fout_r;
    c_s     = c_r;
    z_s     = z_r;
    n_s     = n_r;
    v_s     = v_r;
    err_s   = err_r;
`ifdef ALU_SHIFT_EN
    work_s  = work_r;
    cnt_s   = cnt_r;
    shop_s  = shop_r;
`endif
    case (state_r)
      IDLE: begin
        if (bus.in_valid && go_shift_s) begin
          state_s = SHIFT;
`ifdef ALU_SHIFT_EN
          work_s  = bus.a;
          cnt_s   = bus.b[SHW-1:0];
          shop_s  = bus.fsec[1:0];
`endif
        end else if (bus.in_valid) begin
          state_s = DONE;
          fout_s  = res_s;
          c_s     = rc_s;
          z_s     = (res_s == {WIDTH{1'b0}}) && !rerr_s;
          n_s     = res_s[WIDTH-1];
          v_s     = rv_s;
          err_s   = rerr_s;
        end else begin
          state_s = IDLE;
        end
      end
`ifdef ALU_SHIFT_EN
      SHIFT: begin
        work_s = shifted_s;
        cnt_s  = cnt_r - CNT_ONE;
        if (cnt_r == CNT_ONE) begin
          state_s = DONE;
          fout_s  = shifted_s;
          c_s     = sc_s;
          z_s     = (shifted_s == {WIDTH{1'b0}});
          n_s     = shifted_s[WIDTH-1];
          v_s     = 1'b0;
          err_s   = 1'b0;
        end else begin
          state_s = SHIFT;
        end
      end
`endif
      DONE: begin
        if (bus.out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State and registered outputs; handshake outputs are decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      fout_r      <= {WIDTH{1'b0}};
      c_r         <= 1'b0;
      z_r         <= 1'b0;
      n_r         <= 1'b0;
      v_r         <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
      fout_r      <= fout_s;
      c_r         <= c_s;
      z_r         <= z_s;
      n_r         <= n_s;
      v_r         <= v_s;
      err_r       <= err_s;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.fout      = fout_r;
  assign bus.flag_c    = c_r;
  assign bus.flag_z    = z_r;
  assign bus.flag_n    = n_r;
  assign bus.flag_v    = v_r;
  assign bus.err       = err_r;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq with WIDTH=64; random and directed operations
// are compared with an arithmetic reference model (shift tests follow ALU_SHIFT_EN).
module tb_alu_seq;
  localparam int W = 64;
`ifdef ALU_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif

  typedef logic [W+4:0] obs_t;  // {fout, c, z, n, v, err}

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();
  alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Reference: values computed from the op definitions with wide integer arithmetic.
  function automatic obs_t model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, output int lat);
    logic signed [W+1:0] sa, sb, t;
    logic [W:0]   u;
    logic [W-1:0] r;
    logic         c, v, e, arith;
    int           n;
    sa = $signed({{2{a[W-1]}}, a});
    sb = $signed({{2{b[W-1]}}, b});
    t = '0; r = '0; c = 1'b0; v = 1'b0; e = 1'b0; arith = 1'b0; lat = 1;
    n = int'(b[5:0]);
    case (op)
      5'd0, 5'd1: begin
        u = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, (op == 5'd1) && cin};
        r = u[W-1:0]; c = u[W]; arith = 1'b1;
        t = sa + sb + $signed({{(W+1){1'b0}}, (op == 5'd1) && cin});
      end
      5'd2: begin r = a - b; c = (a >= b); t = sa - sb; arith = 1'b1; end
      5'd3: begin r = b - a; c = (b >= a); t = sb - sa; arith = 1'b1; end
      5'd4: begin r = a + 1; c = (a == '1); t = sa + 1; arith = 1'b1; end
      5'd5: begin r = a - 1; c = (a != '0); t = sa - 1; arith = 1'b1; end
      5'd8:  r = a & b;
      5'd9:  r = a | b;
      5'd10: r = a ^ b;
      5'd11: r = ~a;
      5'd12: r = b;
      5'd16, 5'd17, 5'd18, 5'd19: begin
        if (!SHIFT_EN) e = 1'b1;
        else begin
          lat = (n == 0) ? 1 : 1 + n;
          case (op)
            5'd16: begin r = a << n; c = (n == 0) ? 1'b0 : a[W-n]; end
            5'd17: begin r = a >> n; c = (n == 0) ? 1'b0 : a[n-1]; end
            5'd18: begin r = $signed(a) >>> n; c = (n == 0) ? 1'b0 : a[n-1]; end
            default: begin
              r = (n == 0) ? a : ((a << n) | (a >> (W - n)));
              c = (n == 0) ? 1'b0 : r[0];
            end
          endcase
        end
      end
      default: e = 1'b1;
    endcase
    if (arith) v = (t != $signed({{2{t[W-1]}}, t[W-1:0]}));
    return {r, c, (r == '0) && !e, r[W-1], v, e};
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  function automatic obs_t observe();
    return {bus.fout, bus.flag_c, bus.flag_z, bus.flag_n, bus.flag_v, bus.err};
  endfunction

  // Present one operation, wait (bounded) for out_valid; lat counts edges including the accept edge.
  task automatic do_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, output obs_t o, output int lat);
    @(negedge clk);
    bus.fsec = op; bus.a = a; bus.b = b; bus.carry = cin; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    o = observe();
  endtask

  task automatic take_result();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, observe()} !== {1'b1, 1'b0, {(W+5){1'b0}}}) begin
      errors++;
      $display("FAIL reset_values: got rdy=%b vld=%b obs=%h, want rdy=1 vld=0 obs=0",
               bus.in_ready, bus.out_valid, observe());
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    obs_t o; int lat;
    do_op(5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, o, lat);
    checks++;
    if (o !== {64'd0, 5'b11000} || lat !== 1) begin
      errors++; $display("FAIL add_wrap: got %h lat %0d, want %h lat 1", o, lat, {64'd0, 5'b11000});
    end
    take_result();
    do_op(5'd2, 64'h8000_0000_0000_0000, 64'd1, 1'b0, o, lat);
    checks++;
    if (o !== {64'h7FFF_FFFF_FFFF_FFFF, 5'b10010}) begin
      errors++; $display("FAIL sub_ovf: got %h, want %h", o, {64'h7FFF_FFFF_FFFF_FFFF, 5'b10010});
    end
    take_result();
    do_op(5'd3, 64'd5, 64'd3, 1'b0, o, lat);
    checks++;
    if (o !== {64'hFFFF_FFFF_FFFF_FFFE, 5'b00100}) begin
      errors++; $display("FAIL rsb_neg: got %h, want %h", o, {64'hFFFF_FFFF_FFFF_FFFE, 5'b00100});
    end
    take_result();
    do_op(5'd7, 64'h1234, 64'h5678, 1'b1, o, lat);
    checks++;
    if (o !== {64'd0, 5'b00001} || lat !== 1) begin
      errors++; $display("FAIL illegal_op7: got %h lat %0d, want err only, lat 1", o, lat);
    end
    take_result();
`ifdef ALU_SHIFT_EN
    do_op(5'd18, 64'h8000_0000_0000_0001, 64'd4, 1'b0, o, lat);
    checks++;
    if (o !== {64'hF800_0000_0000_0000, 5'b00100} || lat !== 5) begin
      errors++; $display("FAIL sra4: got %h lat %0d, want %h lat 5", o, lat, {64'hF800_0000_0000_0000, 5'b00100});
    end
    take_result();
    do_op(5'd16, 64'h9234_5678_9ABC_DEF0, 64'hFFFF_FFFF_FFFF_FFC0, 1'b0, o, lat);
    checks++;
    if (o !== {64'h9234_5678_9ABC_DEF0, 5'b00100} || lat !== 1) begin
      errors++; $display("FAIL sll0: got %h lat %0d, want a unchanged, lat 1", o, lat);
    end
    take_result();
`else
    do_op(5'd16, 64'h1234, 64'd3, 1'b0, o, lat);
    checks++;
    if (o !== {64'd0, 5'b00001} || lat !== 1) begin
      errors++; $display("FAIL sll_disabled: got %h lat %0d, want err only, lat 1", o, lat);
    end
    take_result();
`endif
  endtask

  task automatic test_random();
    obs_t o, exp; int lat, elat;
    logic [4:0] op; logic [W-1:0] a, b; logic cin;
    for (int i = 0; i < 80; i++) begin
      op = 5'($urandom_range(0, 31));
      a = pick(); b = pick(); cin = 1'($urandom_range(0, 1));
      exp = model(op, a, b, cin, elat);
      do_op(op, a, b, cin, o, lat);
      checks++;
      if (o !== exp || lat !== elat) begin
        errors++;
        $display("FAIL random op=%0d a=%h b=%h cin=%b: got %h lat %0d, want %h lat %0d",
                 op, a, b, cin, o, lat, exp, elat);
      end
      take_result();
    end
  endtask

  task automatic test_hold();
    obs_t o, exp, snap; int lat, elat;
    logic [W-1:0] a;
    a = {$urandom(), $urandom()};
    exp = model(5'd10, a, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, elat);
    do_op(5'd10, a, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, o, lat);
    snap = o;
    checks++;
    if (o !== exp) begin
      errors++; $display("FAIL hold_result: got %h, want %h", o, exp);
    end
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1; bus.fsec = 5'd0; bus.a = {$urandom(), $urandom()}; bus.b = 64'd7;
      @(posedge clk); #1;
      checks++;
      if ({bus.in_ready, bus.out_valid, observe()} !== {1'b0, 1'b1, snap}) begin
        errors++;
        $display("FAIL hold_stable cycle %0d: got rdy=%b vld=%b obs=%h, want rdy=0 vld=1 obs=%h",
                 i, bus.in_ready, bus.out_valid, observe(), snap);
      end
    end
    bus.in_valid = 1'b0;
    take_result();
    checks++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      errors++; $display("FAIL hold_release: got rdy=%b vld=%b, want rdy=1 vld=0", bus.in_ready, bus.out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      errors++; $display("FAIL hold_ignored_input: got rdy=%b vld=%b, want rdy=1 vld=0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o, exp2; int elat;
    logic [W-1:0] a2, b2;
    a2 = {$urandom(), $urandom()}; b2 = {$urandom(), $urandom()};
    exp2 = model(5'd2, a2, b2, 1'b0, elat);
    @(negedge clk);
    bus.fsec = 5'd9; bus.a = 64'h00FF; bus.b = 64'hFF00; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.out_valid, bus.fout} !== {1'b1, 64'hFFFF}) begin
      errors++; $display("FAIL b2b_first: got vld=%b fout=%h, want vld=1 fout=ffff", bus.out_valid, bus.fout);
    end
    bus.fsec = 5'd2; bus.a = a2; bus.b = b2; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      errors++; $display("FAIL b2b_idle: got rdy=%b vld=%b, want rdy=1 vld=0", bus.in_ready, bus.out_valid);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    o = observe();
    checks++;
    if (bus.out_valid !== 1'b1 || o !== exp2) begin
      errors++; $display("FAIL b2b_second: got vld=%b obs=%h, want vld=1 obs=%h", bus.out_valid, o, exp2);
    end
    take_result();
  endtask

  task automatic test_reset_mid();
    obs_t o; int lat;
    logic seen;
    do_op(5'd0, 64'd1, 64'd1, 1'b0, o, lat);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, observe()} !== {1'b1, 1'b0, {(W+5){1'b0}}}) begin
      errors++;
      $display("FAIL reset_in_done: got rdy=%b vld=%b obs=%h, want rdy=1 vld=0 obs=0",
               bus.in_ready, bus.out_valid, observe());
    end
    @(negedge clk);
    rst = 1'b0;
`ifdef ALU_SHIFT_EN
    @(negedge clk);
    bus.fsec = 5'd19; bus.a = {$urandom(), $urandom()}; bus.b = 64'd63; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid} !== 2'b00) begin
      errors++; $display("FAIL rol_busy: got rdy=%b vld=%b, want rdy=0 vld=0", bus.in_ready, bus.out_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, observe()} !== {1'b1, 1'b0, {(W+5){1'b0}}}) begin
      errors++;
      $display("FAIL reset_in_shift: got rdy=%b vld=%b obs=%h, want rdy=1 vld=0 obs=0",
               bus.in_ready, bus.out_valid, observe());
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); #1;
      seen = seen | bus.out_valid;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL reset_discard: got out_valid=%b after reset, want 0", seen);
    end
`else
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      seen = seen | bus.out_valid;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL reset_discard: got out_valid=%b after reset, want 0", seen);
    end
`endif
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = '0; bus.b = '0;
    bus.fsec = 5'd0; bus.carry = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
